game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 2097152: board_clk cycles per game_tick, min 2.
REQ-002 Parameter SHOTS_PER_LEVEL, default 10: shots granted per level, 1..15.
REQ-003 Parameter LEVEL_TICKS, default 255: game_ticks allowed per level, 1..255 (GAME_TIMEOUT_EN only).
REQ-004 board_clk  in  1  system clock.
REQ-005 reset  in  1  asynchronous, active-high reset; clock is board_clk.
REQ-006 start  in  1  asynchronous level from switch; rising edge advances QI->QGAME_1 and QDONE->QI.
REQ-007 fire_req  in  1  level from fire button, sampled only on game_tick.
REQ-008 hit_valid  in  1  one-cycle pulse: active bullet struck a target.
REQ-009 bullet_done  in  1  one-cycle pulse: active bullet left the field without a hit.
REQ-010 all_hit  in  1  level: every target of the current level is hit.
REQ-011 state  out  2  00 QI, 01 QGAME_1, 10 QGAME_2, 11 QDONE.
REQ-012 game_tick  out  1  one-cycle pulse every TICK_DIV cycles, only in QGAME_1/QGAME_2.
REQ-013 objects_reset  out  1  one-cycle pulse on every entry to QGAME_1 or QGAME_2.
REQ-014 fire_grant  out  1  one-cycle pulse authorising one bullet launch.
REQ-015 bullet_active  out  1  granted bullet in flight.
REQ-016 shots_left  out  4  shots remaining in current level.
REQ-017 score  out  4  total hits, saturating at 15.
REQ-018 win  out  1  valid in QDONE: 1 = both levels cleared, 0 = lost.
REQ-019 time_left  out  8  game_ticks remaining in level; constant 0 without GAME_TIMEOUT_EN.

Function
REQ-020 start SHALL pass a two-flop synchronizer then a rising-edge detector; the edge SHALL act 3 cycles after the input transition.
REQ-021 Tick counter SHALL count 0..TICK_DIV-1, wrap to 0 and pulse game_tick on the wrap cycle; it SHALL be held at 0 in QI/QDONE and cleared on objects_reset.
REQ-022 QI + start edge SHALL go to QGAME_1 next cycle with objects_reset=1, shots_left=SHOTS_PER_LEVEL, score=0, bullet_active=0.
REQ-023 On game_tick with fire_req=1, bullet_active=0, shots_left>0: fire_grant=1 in the following cycle, shots_left decrements by 1, bullet_active sets; otherwise fire_req SHALL be ignored.
REQ-024 hit_valid with bullet_active=1 SHALL clear bullet_active and increment score (saturating); hit_valid with bullet_active=0 SHALL be ignored.
REQ-025 bullet_done SHALL clear bullet_active; hit_valid and bullet_done in the same cycle SHALL count as one hit.
REQ-026 all_hit=1 with bullet_active=0 in QGAME_1 SHALL go to QGAME_2 with objects_reset, shots_left refilled, score kept.
REQ-027 all_hit=1 with bullet_active=0 in QGAME_2 SHALL go to QDONE with win=1.
REQ-028 shots_left=0, bullet_active=0, all_hit=0 in a game state SHALL go to QDONE with win=0; all_hit=1 in the same cycle SHALL take priority (win).
REQ-029 QDONE SHALL hold all outputs except fire_grant/objects_reset/game_tick (0); start edge SHALL return to QI and clear score, win.
REQ-030 start edges in QGAME_1/QGAME_2 SHALL be ignored.

Reset
REQ-031 reset SHALL immediately force state=QI, score=0, shots_left=0, bullet_active=0, win=0, time_left=0, all pulse outputs 0, tick counter and synchronizer flops 0.
REQ-032 reset asserted mid-level SHALL discard the level; no objects_reset SHALL occur until the next start edge.

Configuration
REQ-033 Macro GAME_TIMEOUT_EN defined: time_left loads LEVEL_TICKS on each objects_reset, decrements on each game_tick, and reaching 0 in a game state SHALL go to QDONE with win=0 (all_hit same cycle wins).
REQ-034 GAME_TIMEOUT_EN undefined: no timer logic; time_left tied to 0; levels have no time limit.

Verification (TICK_DIV=4, SHOTS_PER_LEVEL=3, LEVEL_TICKS=5)
REQ-035 Reset, then start 0->1 -> state=01 and objects_reset pulse 3 cycles later, shots_left=3, score=0.
REQ-036 fire_req held 1 for 3 ticks, no hit/bullet_done -> exactly one fire_grant, shots_left=2, bullet_active=1.
REQ-037 Three grants each ended by bullet_done, all_hit=0 -> state=11, win=0, score=0.
REQ-038 all_hit=1 in QGAME_1, then hit then all_hit=1 in QGAME_2 -> state 01->10 (objects_reset, shots_left=3) ->11, win=1.
REQ-039 hit_valid and bullet_done same cycle, then hit_valid with no bullet -> score increments once only.
REQ-040 GAME_TIMEOUT_EN, no hits -> state=11, win=0 after 5 game_ticks; reset mid-level -> state=00 immediately.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: flow controller for a two-level shooting game.
// Handles the start switch, the game tick, shot accounting, scoring, and the
// QI -> QGAME_1 -> QGAME_2 -> QDONE progression.
// Optional level timer: define GAME_TIMEOUT_EN to enable time_left and the
// time-out loss. Without it, time_left is 0 and levels have no time limit.
module game_flow_ctrl #(
  parameter int TICK_DIV        = 2097152,
  parameter int SHOTS_PER_LEVEL = 10,
  parameter int LEVEL_TICKS     = 255
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       fire_req,
  input  logic       hit_valid,
  input  logic       bullet_done,
  input  logic       all_hit,
  output logic [1:0] state,
  output logic       game_tick,
  output logic       objects_reset,
  output logic       fire_grant,
  output logic       bullet_active,
  output logic [3:0] shots_left,
  output logic [3:0] score,
  output logic       win,
  output logic [7:0] time_left
);

  localparam int            TW         = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [3:0]    SHOTS_INIT = 4'(SHOTS_PER_LEVEL);

  // Reject out-of-range configurations at elaboration.
  if (TICK_DIV < 2 || SHOTS_PER_LEVEL < 1 || SHOTS_PER_LEVEL > 15 ||
      LEVEL_TICKS < 1 || LEVEL_TICKS > 255) begin : g_bad_params
    $error("game_flow_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  state_t        state_reg, state_next;
  logic          start_meta, start_sync, start_prev, start_edge;
  logic [TW-1:0] tick_reg, tick_next;
  logic [3:0]    shots_reg, shots_next, score_reg, score_next;
  logic          bullet_reg, bullet_next, win_reg, win_next;
  logic          grant_reg, grant_next, objrst_reg, objrst_next;
  logic          in_game, next_in_game, time_out;

`ifdef GAME_TIMEOUT_EN
  localparam logic [7:0] TIME_INIT = 8'(LEVEL_TICKS);
  logic [7:0] time_reg, time_next;

  assign time_out  = (time_reg == 8'd0);
  assign time_left = time_reg;

  // Level timer register.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) time_reg <= 8'd0;
    else       time_reg <= time_next;
  end
`else
  assign time_out  = 1'b0;
  assign time_left = 8'd0;
`endif

  // The switch is asynchronous: two flops, then a third to find the rising edge.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      start_meta <= start;
      start_sync <= start_meta;
      start_prev <= start_sync;
    end
  end

  assign start_edge   = start_sync & ~start_prev;
  assign in_game      = (state_reg == QGAME_1) || (state_reg == QGAME_2);
  assign next_in_game = (state_next == QGAME_1) || (state_next == QGAME_2);
  assign game_tick    = in_game && (tick_reg == TICK_LAST);

  // State and game-bookkeeping registers.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_reg  <= QI;
      tick_reg   <= '0;
      shots_reg  <= 4'd0;
      score_reg  <= 4'd0;
      bullet_reg <= 1'b0;
      win_reg    <= 1'b0;
      grant_reg  <= 1'b0;
      objrst_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tick_reg   <= tick_next;
      shots_reg  <= shots_next;
      score_reg  <= score_next;
      bullet_reg <= bullet_next;
      win_reg    <= win_next;
      grant_reg  <= grant_next;
      objrst_reg <= objrst_next;
    end
  end

  // Next state: level transitions take priority over shot and hit bookkeeping.
  always_comb begin
    state_next  = state_reg;
    shots_next  = shots_reg;
    score_next  = score_reg;
    bullet_next = bullet_reg;
    win_next    = win_reg;
    grant_next  = 1'b0;
    objrst_next = 1'b0;
`ifdef GAME_TIMEOUT_EN
    time_next   = time_reg;
`endif
    case (state_reg)
      QI: begin
        if (start_edge) begin
          state_next  = QGAME_1;
          objrst_next = 1'b1;
          shots_next  = SHOTS_INIT;
          score_next  = 4'd0;
          bullet_next = 1'b0;
`ifdef GAME_TIMEOUT_EN
          time_next   = TIME_INIT;
`endif
        end
      end
      QGAME_1, QGAME_2: begin
        if (all_hit && !bullet_reg) begin
          if (state_reg == QGAME_1) begin
            state_next  = QGAME_2;
            objrst_next = 1'b1;
            shots_next  = SHOTS_INIT;
`ifdef GAME_TIMEOUT_EN
            time_next   = TIME_INIT;
`endif
          end else begin
            state_next = QDONE;
            win_next   = 1'b1;
          end
        end else if ((shots_reg == 4'd0 && !bullet_reg) || time_out) begin
          state_next = QDONE;
          win_next   = 1'b0;
        end else begin
          if (game_tick && fire_req && !bullet_reg && shots_reg != 4'd0) begin
            grant_next  = 1'b1;
            shots_next  = shots_reg - 4'd1;
            bullet_next = 1'b1;
          end
          // A simultaneous bullet_done adds nothing beyond the hit.
          if (bullet_reg && hit_valid) begin
            bullet_next = 1'b0;
            if (score_reg != 4'd15) score_next = score_reg + 4'd1;
          end else if (bullet_reg && bullet_done) begin
            bullet_next = 1'b0;
          end
`ifdef GAME_TIMEOUT_EN
          if (game_tick && time_reg != 8'd0) time_next = time_reg - 8'd1;
`endif
        end
      end
      QDONE: begin
        if (start_edge) begin
          state_next = QI;
          score_next = 4'd0;
          win_next   = 1'b0;
        end
      end
      default: state_next = QI;
    endcase
  end

  // Tick counter: idle outside play, restarted at every level entry.
  always_comb begin
    tick_next = tick_reg + TW'(1);
    if (!next_in_game || objrst_next || tick_reg == TICK_LAST) tick_next = '0;
  end

  assign state         = state_reg;
  assign objects_reset = objrst_reg;
  assign fire_grant    = grant_reg;
  assign bullet_active = bullet_reg;
  assign shots_left    = shots_reg;
  assign score         = score_reg;
  assign win           = win_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: table-driven, hand-written, and randomized checks of game_flow_ctrl.
module tb_game_flow_ctrl;

  localparam int TD = 4;
  localparam int SH = 3;
  localparam int LT = 5;

  logic       board_clk = 1'b0;
  logic       reset, start, fire_req, hit_valid, bullet_done, all_hit;
  logic [1:0] state;
  logic       game_tick, objects_reset, fire_grant, bullet_active, win;
  logic [3:0] shots_left, score;
  logic [7:0] time_left;

  int tests = 0;
  int fails = 0;

  game_flow_ctrl #(.TICK_DIV(TD), .SHOTS_PER_LEVEL(SH), .LEVEL_TICKS(LT)) dut (
    .board_clk(board_clk), .reset(reset), .start(start), .fire_req(fire_req),
    .hit_valid(hit_valid), .bullet_done(bullet_done), .all_hit(all_hit),
    .state(state), .game_tick(game_tick), .objects_reset(objects_reset),
    .fire_grant(fire_grant), .bullet_active(bullet_active), .shots_left(shots_left),
    .score(score), .win(win), .time_left(time_left)
  );

  always #5 board_clk = ~board_clk;

  // ---------------- behavioural reference model ----------------
  // States: 0 idle, 1 level one, 2 level two, 3 done.
  int m_state, m_shots, m_score, m_bullet, m_win, m_grant, m_objrst, m_time, m_phase;
  int hist[3];   // start as sampled at the last three clock edges, newest first

  task automatic m_reset();
    m_state = 0; m_shots = 0; m_score = 0; m_bullet = 0; m_win = 0;
    m_grant = 0; m_objrst = 0; m_time = 0; m_phase = 0;
    hist[0] = 0; hist[1] = 0; hist[2] = 0;
  endtask

  function automatic bit m_tick();
    return (m_state == 1 || m_state == 2) && (m_phase % TD == TD - 1);
  endfunction

  function automatic bit m_timed_out();
`ifdef GAME_TIMEOUT_EN
    return m_time == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_begin_level();
    m_objrst = 1; m_shots = SH; m_bullet = 0; m_phase = 0;
`ifdef GAME_TIMEOUT_EN
    m_time = LT;
`endif
  endtask

  task automatic model_step(input bit s, input bit f, input bit h, input bit d, input bit a);
    bit edge_seen, tick;
    edge_seen = (hist[1] == 1) && (hist[2] == 0);
    tick = m_tick();
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = s;
    m_grant = 0; m_objrst = 0;
    if (m_state == 0) begin
      if (edge_seen) begin m_state = 1; m_score = 0; m_begin_level(); end
    end else if (m_state == 3) begin
      if (edge_seen) begin m_state = 0; m_score = 0; m_win = 0; end
    end else begin
      if (a && m_bullet == 0) begin
        if (m_state == 1) begin m_state = 2; m_begin_level(); end
        else begin m_state = 3; m_win = 1; end
      end else if ((m_shots == 0 && m_bullet == 0) || m_timed_out()) begin
        m_state = 3; m_win = 0;
      end else begin
        m_phase++;
        if (tick && m_time > 0) m_time--;
        if (tick && f && m_bullet == 0 && m_shots > 0) begin
          m_grant = 1; m_shots--; m_bullet = 1;
        end else if (m_bullet == 1 && h) begin
          m_bullet = 0; m_score = (m_score < 15) ? m_score + 1 : 15;
        end else if (m_bullet == 1 && d) begin
          m_bullet = 0;
        end
      end
    end
  endtask

  function automatic logic [22:0] m_out();
    return {2'(m_state), m_tick(), 1'(m_objrst), 1'(m_grant), 1'(m_bullet),
            4'(m_shots), 4'(m_score), 1'(m_win), 8'(m_time)};
  endfunction

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; fire_req = 0; hit_valid = 0; bullet_done = 0; all_hit = 0;
    m_reset();
    cyc(2);
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       s, f, h, d, a;
    int         cycles;
    logic [1:0] st;
    logic [3:0] shots, score;
    logic       bullet, w;
  } vec_t;

  vec_t vec[15];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt, waited;
    logic [22:0] act;

    //            s f h d a cyc  st    sh sc  b  w
    vec[0]  = '{1,0,0,0,0, 3, 2'b01, 3, 0, 0, 0};  // start edge after three clocks
    vec[1]  = '{1,1,0,0,0, 4, 2'b01, 2, 0, 1, 0};  // first tick grants a shot
    vec[2]  = '{1,1,0,0,0, 8, 2'b01, 2, 0, 1, 0};  // bullet in flight blocks fire
    vec[3]  = '{1,0,1,1,0, 1, 2'b01, 2, 1, 0, 0};  // hit + done counts once
    vec[4]  = '{1,0,1,0,0, 1, 2'b01, 2, 1, 0, 0};  // hit without bullet ignored
    vec[5]  = '{1,0,0,0,1, 1, 2'b10, 3, 1, 0, 0};  // level one cleared
    vec[6]  = '{1,1,0,0,0, 4, 2'b10, 2, 1, 1, 0};  // grant in level two
    vec[7]  = '{1,0,1,0,0, 1, 2'b10, 2, 2, 0, 0};  // hit
    vec[8]  = '{1,0,0,0,1, 1, 2'b11, 2, 2, 0, 1};  // level two cleared: win
    vec[9]  = '{0,0,0,0,0, 3, 2'b11, 2, 2, 0, 1};  // done holds
    vec[10] = '{1,0,0,0,0, 3, 2'b00, 2, 0, 0, 0};  // start edge back to idle
    vec[11] = '{0,0,0,0,0, 3, 2'b00, 2, 0, 0, 0};
    vec[12] = '{1,0,0,0,0, 3, 2'b01, 3, 0, 0, 0};  // new game
    vec[13] = '{0,0,0,0,0, 3, 2'b01, 3, 0, 0, 0};
    vec[14] = '{1,0,0,0,0, 3, 2'b01, 3, 0, 0, 0};  // start edge in play ignored

    // Reset state while reset is held.
    reset = 1'b1; start = 0; fire_req = 0; hit_valid = 0; bullet_done = 0; all_hit = 0;
    cyc(1);
    check("reset_outputs",
          {state, game_tick, objects_reset, fire_grant, bullet_active, shots_left, score, win, time_left},
          23'd0);
    reset = 1'b0;

    // Table-driven sequence.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      start = vec[i].s; fire_req = vec[i].f; hit_valid = vec[i].h;
      bullet_done = vec[i].d; all_hit = vec[i].a;
      cyc(vec[i].cycles);
      check($sformatf("vec%0d", i), {state, shots_left, score, bullet_active, win},
            {vec[i].st, vec[i].shots, vec[i].score, vec[i].bullet, vec[i].w});
      $display("[TB] vec%0d state=%b shots=%0d score=%0d bullet=%b win=%b",
               i, state, shots_left, score, bullet_active, win);
    end

    // Start edge latency and objects_reset pulse.
    do_reset();
    start = 1'b1;
    cyc(1); check("start_lat1_state", state, 2'b00);
    cyc(1); check("start_lat2_state", state, 2'b00);
            check("start_lat2_objrst", objects_reset, 1'b0);
    cyc(1); check("start_lat3_state", state, 2'b01);
            check("start_lat3_objrst", objects_reset, 1'b1);
            check("start_lat3_shots", shots_left, 4'd3);
            check("start_lat3_score", score, 4'd0);
    cyc(1); check("objrst_one_cycle", objects_reset, 1'b0);
    $display("[TB] start latency sequence done");

    // fire_req held over three ticks gives exactly one grant.
    do_reset();
    start = 1'b1; cyc(3);
    fire_req = 1'b1; cnt = 0;
    for (int i = 0; i < 12; i++) begin cyc(1); if (fire_grant) cnt++; end
    fire_req = 1'b0;
    check("held_fire_grants", cnt, 1);
    check("held_fire_shots", shots_left, 4'd2);
    check("held_fire_bullet", bullet_active, 1'b1);
    $display("[TB] held fire: grants=%0d shots=%0d", cnt, shots_left);

    // Three misses lose the game.
    do_reset();
    start = 1'b1; cyc(3);
    fire_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      waited = 0;
      while (fire_grant !== 1'b1 && waited < 20) begin cyc(1); waited++; end
      check($sformatf("miss_grant%0d", g), fire_grant, 1'b1);
      bullet_done = 1'b1; cyc(1); bullet_done = 1'b0;
    end
    fire_req = 1'b0;
    cyc(2);
    check("miss_state", state, 2'b11);
    check("miss_win", win, 1'b0);
    check("miss_score", score, 4'd0);
    $display("[TB] three misses: state=%b win=%b", state, win);

    // Reset mid-level acts immediately and no level starts afterwards.
    do_reset();
    start = 1'b1; cyc(5);
    #2 reset = 1'b1;
    #1 check("midreset_state", state, 2'b00);
    check("midreset_shots", shots_left, 4'd0);
    start = 1'b0;
    cyc(2);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin cyc(1); if (objects_reset) cnt++; end
    check("midreset_no_objrst", cnt, 0);
    check("midreset_idle", state, 2'b00);
    $display("[TB] mid-level reset: state=%b objrst_count=%0d", state, cnt);

`ifdef GAME_TIMEOUT_EN
    // Timeout after LEVEL_TICKS game ticks with no shots fired.
    do_reset();
    start = 1'b1; cyc(3);
    check("timeout_load", time_left, 8'd5);
    cnt = 0; waited = 0;
    while (state !== 2'b11 && waited < 100) begin cyc(1); waited++; if (game_tick) cnt++; end
    check("timeout_state", state, 2'b11);
    check("timeout_ticks", cnt, LT);
    check("timeout_win", win, 1'b0);
    $display("[TB] timeout: ticks=%0d state=%b", cnt, state);
`endif

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      act = {state, game_tick, objects_reset, fire_grant, bullet_active,
             shots_left, score, win, time_left};
      tests++;
      if (act !== m_out()) begin
        fails++;
        $display("FAIL rand_cycle%0d: got %h, expected %h", c, act, m_out());
      end
      if ($urandom_range(39) == 0) start = ~start;
      fire_req    = 1'($urandom_range(1));
      hit_valid   = ($urandom_range(7) == 0);
      bullet_done = ($urandom_range(9) == 0);
      if ($urandom_range(15) == 0) all_hit = ~all_hit;
      model_step(start, fire_req, hit_valid, bullet_done, all_hit);
      cyc(1);
    end
    $display("[TB] random run of 4000 cycles done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
